// File: rtl/jk_cmd_issuer.sv
// jk_cmd_issuer: queues JK commands and issues them as one-cycle J/K pairs with idle gaps.
// Optional JK_SHADOW_CHECK_EN builds the q_fb vs shadow_q sticky mismatch check.
module jk_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  output logic                     J,
  output logic                     K,
  output logic                     issue_pulse,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     shadow_q,
  input  logic                     q_fb,
  output logic                     mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] GAP_LD = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  state_t      state;
  logic [1:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [3:0]  gap_cnt;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [1:0]  head;

  assign level     = wr_ptr - rd_ptr;
  assign full      = level == (AW+1)'(DEPTH);
  assign empty     = wr_ptr == rd_ptr;
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign busy      = !empty || (state != S_IDLE);

  always_comb begin
    pop = 1'b0;
    unique case (state)
      S_IDLE:  pop = !empty;
      S_ISSUE: pop = !empty && (GAP == 0);
      S_GAP:   pop = !empty && (gap_cnt == 4'd0);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= cmd_op;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      J           <= 1'b0;
      K           <= 1'b0;
      issue_pulse <= 1'b0;
      gap_cnt     <= 4'd0;
    end else begin
      J           <= 1'b0;
      K           <= 1'b0;
      issue_pulse <= 1'b0;
      if (pop) begin
        {J, K}      <= head;
        issue_pulse <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (pop)
            state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (GAP > 0) begin
            state   <= S_GAP;
            gap_cnt <= GAP_LD;
          end else if (!pop) begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0)
            state <= pop ? S_ISSUE : S_IDLE;
          else
            gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The downstream flop samples J/K on the edge after issue_pulse rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= 1'b0;
    end else if (issue_pulse) begin
      case ({J, K})
        2'b01:   shadow_q <= 1'b0;
        2'b10:   shadow_q <= 1'b1;
        2'b11:   shadow_q <= ~shadow_q;
        default: shadow_q <= shadow_q;
      endcase
    end
  end

`ifdef JK_SHADOW_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mismatch <= 1'b0;
    else if (!issue_pulse && (q_fb != shadow_q))
      mismatch <= 1'b1;
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign mismatch    = 1'b0;
`endif

endmodule
